hls_test1_sched: RTL and testbench
==================================

Name: hls_test1_sched

Overview:
Resource-constrained FSMD controller that computes the hls_test1 function with one shared ALU (add/sub/compare) and one pipelined multiplier instead of per-operation units.
- Function: d=a+b, e=a+c, z=(d>e)?d[7:0]:e[7:0], x=(a*c)-d.
- Same Start/Done handshake and port set as the combinationally scheduled hls_test1 block, so the two are drop-in interchangeable in benches.
- Trades latency for area.

Parameters:
DATAWIDTH, 16, width of a, b, c, x and all intermediates.
ZWIDTH, 8, width of z (low ZWIDTH bits of the selected sum).
MUL_LAT, 2, multiplier pipeline depth in cycles (1..6).

Ports:
Clk  input  1  clock, rising edge.
Rst  input  1  synchronous, active-high reset.
Start  input  1  request; sampled only in state WAIT.
a  input  DATAWIDTH  operand, unsigned.
b  input  DATAWIDTH  operand, unsigned.
c  input  DATAWIDTH  operand, unsigned.
Done  output  1  one-cycle pulse when z and x are valid.
z  output  ZWIDTH  result, registered.
x  output  DATAWIDTH  result, registered.

Behaviour:
- Interface: Clk; reset Rst, synchronous, active-high.
- Reset values: state=WAIT, Done=0, z=0, x=0. All internal regs (ra, rb, rc, d, e, g, f) = 0. Multiplier valid pipeline flushed.
- Arithmetic: all unsigned, modulo 2^DATAWIDTH. f = low DATAWIDTH bits of the product. The compare is strict, so a tie (d==e) selects e.
- States:
  - WAIT: if Start=1, capture a/b/c into ra/rb/rc and go to S1. Otherwise stay. Done=0.
  - S1: ALU d<=ra+rb. Issue mul ra*rc (mul_in_valid=1). Go to S2.
  - S2: ALU e<=ra+rc. Go to S3.
  - S3: ALU g<=(d>e), via subtract/borrow. Go to S4.
  - S4: z<=g?d[ZWIDTH-1:0]:e[ZWIDTH-1:0]. If mul_out_valid (this cycle, or latched earlier into f), go to S5. Otherwise stall in S4 with z held.
  - S5: ALU x<=f-d. Go to FINAL.
  - FINAL: Done=1 for exactly this cycle. Go to WAIT.
- Latency: with MUL_LAT<=3, Done is high 6 cycles after the Start-sampling edge (no stall). Each MUL_LAT beyond 3 adds one stall cycle in S4.
- Multiplier: the product is latched into f on mul_out_valid, whatever the current state.
- Start while busy: ignored; a/b/c changes after capture have no effect.
- Start held high: the block re-enters S1 on the cycle after FINAL→WAIT, so results pulse back-to-back with one WAIT cycle between.
- Output timing: z updates in S4 and x in S5. Both hold their values until overwritten in the next run. They are valid to consumers only while Done=1.
- Rst mid-operation: the run aborts and all state returns to reset values on the next edge. No Done pulse. A product still in flight in the multiplier is discarded (its valid is cleared).
- ALU usage: exactly one ALU operation per state (S1, S2, S3, S5). Bench checks this via ALU op-select assertions.

Decomposition:
- Package hls_sched_pkg holds:
  - state encoding localparams: WAIT, S1, S2, S3, S4, S5, FINAL (3-bit);
  - ALU op codes: ADD, SUB, GT;
  - default widths.
- Sub-module hls_mul_pipe(DATAWIDTH, MUL_LAT): registered multiplier with in_valid/out_valid shift chain, reset by Rst.
- The ALU stays inline as a case on the op code.

Test Plan:
- a=10, b=20, c=30, one Start pulse → Done exactly 6 cycles later; z=0x28 (40), x=270 (0x010E). Done high for 1 cycle only.
- a=10, b=50, c=30 → z=0x3C (60), x=240. Then a=5, b=7, c=7 (tie) → z=0x0C from e, x=23.
- Wrap/underflow: a=0x8000, b=0x8000, c=2 → d=0, e=0x8002, z=0x02, x=0x0000. Then a=1, b=100, c=1 → z=0x65, x=0xFF9C.
- Start held high for 20 cycles with a=10, b=20, c=30 → Done pulses every 7 cycles, each with z=0x28 and x=270. Changing a to 11 during S2 has no effect on the current result.
- Rst asserted in S3, then Start with a=10, b=20, c=30 → no Done during the aborted run; z and x read 0 after reset; the fresh run gives the correct values 6 cycles after Start.
- MUL_LAT=5 instance, a=3, b=4, c=5 → 2 stall cycles in S4; Done 8 cycles after Start; z=0x08, x=8.

Source files
------------

// File: rtl/hls_sched_pkg.sv
// Shared encodings and default widths for the resource-constrained hls_test1 controller.
package hls_sched_pkg;

    localparam int DATAWIDTH_DEF = 16;
    localparam int ZWIDTH_DEF    = 8;
    localparam int MUL_LAT_DEF   = 2;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_S1    = 3'd1,
        ST_S2    = 3'd2,
        ST_S3    = 3'd3,
        ST_S4    = 3'd4,
        ST_S5    = 3'd5,
        ST_FINAL = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ALU_NOP = 2'd0,
        ALU_ADD = 2'd1,
        ALU_SUB = 2'd2,
        ALU_GT  = 2'd3
    } alu_op_t;

endpackage

// File: rtl/hls_test1_sched_mul.sv
// Pipelined unsigned multiplier: product truncated to DATAWIDTH bits, valid travels
// alongside the data so the controller can tell when the result has arrived.
module hls_mul_pipe #(
    parameter int DATAWIDTH = 16,
    parameter int MUL_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATAWIDTH-1:0] in_a,
    input  logic [DATAWIDTH-1:0] in_b,
    output logic                 out_valid,
    output logic [DATAWIDTH-1:0] out_p
);

    logic [DATAWIDTH-1:0] p_pipe [MUL_LAT];
    logic [MUL_LAT-1:0]   v_pipe;

    // Product/valid shift chain; reset flushes any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                p_pipe[i] <= '0;
            end
        end else begin
            v_pipe[0] <= in_valid;
            p_pipe[0] <= in_a * in_b;
            for (int i = 1; i < MUL_LAT; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                p_pipe[i] <= p_pipe[i-1];
            end
        end
    end

    assign out_valid = v_pipe[MUL_LAT-1];
    assign out_p     = p_pipe[MUL_LAT-1];

endmodule

// File: rtl/hls_test1_sched.sv
// FSMD computing z=(d>e)?d:e (low bits) and x=a*c-d with one shared ALU and one
// pipelined multiplier; Start/Done handshake matches the unscheduled hls_test1 block.
module hls_test1_sched
    import hls_sched_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int ZWIDTH    = ZWIDTH_DEF,
    parameter int MUL_LAT   = MUL_LAT_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    output logic                 Done,
    output logic [ZWIDTH-1:0]    z,
    output logic [DATAWIDTH-1:0] x
);

    state_t               state;
    logic [DATAWIDTH-1:0] ra, rb, rc, d, e, f;
    logic                 g;
    logic                 f_valid;

    alu_op_t              alu_op;
    logic [DATAWIDTH-1:0] alu_a, alu_b, alu_res;
    logic                 alu_gt;

    logic                 mul_in_valid;
    logic                 mul_out_valid;
    logic [DATAWIDTH-1:0] mul_p;

    assign mul_in_valid = (state == ST_S1);

    hls_mul_pipe #(
        .DATAWIDTH (DATAWIDTH),
        .MUL_LAT   (MUL_LAT)
    ) u_mul (
        .clk       (Clk),
        .rst       (Rst),
        .in_valid  (mul_in_valid),
        .in_a      (ra),
        .in_b      (rc),
        .out_valid (mul_out_valid),
        .out_p     (mul_p)
    );

    // ALU operand/op selection: exactly one operation per computing state
    always_comb begin
        alu_op = ALU_NOP;
        alu_a  = '0;
        alu_b  = '0;
        case (state)
            ST_S1:   begin alu_op = ALU_ADD; alu_a = ra; alu_b = rb; end
            ST_S2:   begin alu_op = ALU_ADD; alu_a = ra; alu_b = rc; end
            ST_S3:   begin alu_op = ALU_GT;  alu_a = d;  alu_b = e;  end
            ST_S5:   begin alu_op = ALU_SUB; alu_a = f;  alu_b = d;  end
            default: begin alu_op = ALU_NOP; alu_a = '0; alu_b = '0; end
        endcase
    end

    // Shared ALU; a>b is the borrow out of b-a, so a tie yields 0
    always_comb begin
        alu_res = '0;
        alu_gt  = 1'b0;
        case (alu_op)
            ALU_ADD: alu_res = alu_a + alu_b;
            ALU_SUB: alu_res = alu_a - alu_b;
            ALU_GT:  {alu_gt, alu_res} = {1'b0, alu_b} - {1'b0, alu_a};
            default: begin
                alu_res = '0;
                alu_gt  = 1'b0;
            end
        endcase
    end

    // Controller and datapath registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= ST_WAIT;
            Done    <= 1'b0;
            z       <= '0;
            x       <= '0;
            ra      <= '0;
            rb      <= '0;
            rc      <= '0;
            d       <= '0;
            e       <= '0;
            f       <= '0;
            g       <= 1'b0;
            f_valid <= 1'b0;
        end else begin
            Done <= 1'b0;
            // The product can land in any state; remember that it has arrived
            if (mul_out_valid) begin
                f       <= mul_p;
                f_valid <= 1'b1;
            end
            case (state)
                ST_WAIT: begin
                    if (Start) begin
                        ra    <= a;
                        rb    <= b;
                        rc    <= c;
                        state <= ST_S1;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_S1: begin
                    d     <= alu_res;
                    state <= ST_S2;
                end
                ST_S2: begin
                    e     <= alu_res;
                    state <= ST_S3;
                end
                ST_S3: begin
                    g     <= alu_gt;
                    state <= ST_S4;
                end
                ST_S4: begin
                    z <= g ? d[ZWIDTH-1:0] : e[ZWIDTH-1:0];
                    if (mul_out_valid || f_valid) begin
                        state <= ST_S5;
                    end else begin
                        state <= ST_S4;
                    end
                end
                ST_S5: begin
                    x     <= alu_res;
                    state <= ST_FINAL;
                end
                ST_FINAL: begin
                    Done    <= 1'b1;
                    f_valid <= 1'b0;
                    state   <= ST_WAIT;
                end
                default: begin
                    state <= ST_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hls_test1_sched.sv
// Scoreboard bench for hls_test1_sched: default MUL_LAT=2 instance plus a MUL_LAT=5 instance.
module tb_hls_test1_sched;

    localparam int DW = 16;
    localparam int ZW = 8;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Start;
    logic          start5;
    logic [DW-1:0] a, b, c;
    logic          Done, done5;
    logic [ZW-1:0] z, z5;
    logic [DW-1:0] x, x5;

    typedef struct packed {
        logic [ZW-1:0] z;
        logic [DW-1:0] x;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    hls_test1_sched #(.DATAWIDTH(DW), .ZWIDTH(ZW), .MUL_LAT(2)) u_dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .a(a), .b(b), .c(c),
        .Done(Done), .z(z), .x(x)
    );

    hls_test1_sched #(.DATAWIDTH(DW), .ZWIDTH(ZW), .MUL_LAT(5)) u_dut5 (
        .Clk(Clk), .Rst(Rst), .Start(start5), .a(a), .b(b), .c(c),
        .Done(done5), .z(z5), .x(x5)
    );

    function automatic res_t model(input logic [DW-1:0] ia, input logic [DW-1:0] ib,
                                   input logic [DW-1:0] ic);
        logic [DW-1:0]   d, e;
        logic [2*DW-1:0] p;
        res_t            r;
        d   = ia + ib;
        e   = ia + ic;
        p   = {{DW{1'b0}}, ia} * {{DW{1'b0}}, ic};
        r.z = (d > e) ? d[ZW-1:0] : e[ZW-1:0];
        r.x = p[DW-1:0] - d;
        return r;
    endfunction

    // One-cycle Start pulse; returns just after the sampling edge has passed
    task automatic start_pulse(input bit sel5, input logic [DW-1:0] ia,
                               input logic [DW-1:0] ib, input logic [DW-1:0] ic);
        @(negedge Clk);
        a = ia; b = ib; c = ic;
        if (sel5) start5 = 1'b1; else Start = 1'b1;
        @(negedge Clk);
        Start  = 1'b0;
        start5 = 1'b0;
    endtask

    // Edges counted from the Start-sampling edge until Done; -1 on timeout
    task automatic wait_done(input bit sel5, output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge Clk);
            #1;
            if (sel5 ? done5 : Done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b0; start5 = 1'b0;
        a = '0; b = '0; c = '0;
        repeat (3) @(posedge Clk);
        #1;
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", Done); end
        checks++; if (z !== 8'h00) begin errors++; $display("FAIL reset_z got %h want 00", z); end
        checks++; if (x !== 16'h0000) begin errors++; $display("FAIL reset_x got %h want 0000", x); end
        checks++; if (done5 !== 1'b0 || z5 !== 8'h00 || x5 !== 16'h0000) begin
            errors++; $display("FAIL reset_lat5 got done=%0b z=%h x=%h want 0/00/0000", done5, z5, x5);
        end
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_patterns();
        logic [DW-1:0] va [5];
        logic [DW-1:0] vb [5];
        logic [DW-1:0] vc [5];
        int            lat;
        res_t          exp;
        va = '{16'd10, 16'd10, 16'd5, 16'h8000, 16'd1};
        vb = '{16'd20, 16'd50, 16'd7, 16'h8000, 16'd100};
        vc = '{16'd30, 16'd30, 16'd7, 16'd2,    16'd1};
        for (int k = 0; k < 5; k++) begin
            sb.push_back(model(va[k], vb[k], vc[k]));
            start_pulse(1'b0, va[k], vb[k], vc[k]);
            wait_done(1'b0, lat);
            exp = sb.pop_front();
            checks++; if (lat !== 6) begin errors++; $display("FAIL pat%0d_latency got %0d want 6", k, lat); end
            checks++; if (z !== exp.z) begin errors++; $display("FAIL pat%0d_z got %h want %h", k, z, exp.z); end
            checks++; if (x !== exp.x) begin errors++; $display("FAIL pat%0d_x got %h want %h", k, x, exp.x); end
            @(posedge Clk);
            #1;
            checks++; if (Done !== 1'b0) begin errors++; $display("FAIL pat%0d_done_width got %0b want 0", k, Done); end
        end
        // Hand-derived anchors for the first and last vectors
        checks++; if (model(16'd10, 16'd20, 16'd30) !== {8'h28, 16'h010E}) begin
            errors++; $display("FAIL model_anchor got %h want 28010e", model(16'd10, 16'd20, 16'd30));
        end
        checks++; if (x !== 16'hFF9C || z !== 8'h65) begin
            errors++; $display("FAIL underflow_literal got z=%h x=%h want 65/ff9c", z, x);
        end
    endtask

    task automatic test_back_to_back();
        int   pulses = 0;
        int   last_t = -1;
        res_t exp;
        for (int k = 0; k < 3; k++) sb.push_back(model(16'd10, 16'd20, 16'd30));
        @(negedge Clk);
        a = 16'd10; b = 16'd20; c = 16'd30;
        Start = 1'b1;
        for (int cyc = 0; cyc <= 26; cyc++) begin
            @(posedge Clk);
            #1;
            if (cyc == 1) a = 16'd11;
            if (cyc == 2) a = 16'd10;
            if (cyc == 19) Start = 1'b0;
            if (Done) begin
                pulses++;
                checks++; if (cyc !== (last_t < 0 ? 6 : last_t + 7)) begin
                    errors++; $display("FAIL b2b_spacing pulse%0d at %0d want %0d", pulses, cyc, last_t < 0 ? 6 : last_t + 7);
                end
                last_t = cyc;
                if (sb.size() == 0) begin
                    checks++; errors++; $display("FAIL b2b_extra_pulse at %0d want none", cyc);
                end else begin
                    exp = sb.pop_front();
                    checks++; if (z !== exp.z || x !== exp.x) begin
                        errors++; $display("FAIL b2b_result got z=%h x=%h want z=%h x=%h", z, x, exp.z, exp.x);
                    end
                end
            end
        end
        checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulse_count got %0d want 3", pulses); end
        sb.delete();
    endtask

    task automatic test_reset_abort();
        int   stray = 0;
        int   lat;
        res_t exp;
        start_pulse(1'b0, 16'd10, 16'd50, 16'd30);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        checks++; if (z !== 8'h00 || x !== 16'h0000) begin
            errors++; $display("FAIL abort_outputs got z=%h x=%h want 00/0000", z, x);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            if (Done) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", stray); end
        sb.push_back(model(16'd10, 16'd20, 16'd30));
        start_pulse(1'b0, 16'd10, 16'd20, 16'd30);
        wait_done(1'b0, lat);
        exp = sb.pop_front();
        checks++; if (lat !== 6) begin errors++; $display("FAIL abort_rerun_latency got %0d want 6", lat); end
        checks++; if (z !== exp.z || x !== exp.x) begin
            errors++; $display("FAIL abort_rerun_result got z=%h x=%h want z=%h x=%h", z, x, exp.z, exp.x);
        end
    endtask

    task automatic test_mul_lat5();
        int   lat;
        res_t exp;
        sb.push_back(model(16'd3, 16'd4, 16'd5));
        start_pulse(1'b1, 16'd3, 16'd4, 16'd5);
        wait_done(1'b1, lat);
        exp = sb.pop_front();
        checks++; if (lat !== 8) begin errors++; $display("FAIL lat5_latency got %0d want 8", lat); end
        checks++; if (z5 !== exp.z || x5 !== exp.x) begin
            errors++; $display("FAIL lat5_result got z=%h x=%h want z=%h x=%h", z5, x5, exp.z, exp.x);
        end
        checks++; if (z5 !== 8'h08 || x5 !== 16'd8) begin
            errors++; $display("FAIL lat5_literal got z=%h x=%h want 08/0008", z5, x5);
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_back_to_back();
        test_reset_abort();
        test_mul_lat5();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
